// File: rtl/topk_sorted_buffer.sv
// Top-K nearest-neighbour buffer: keeps the K smallest (distance, index) pairs sorted, then drains them in rank order (TOPK_STATS_EN adds accept/reject counters).
// Latency: one cycle per accepted candidate; threshold and count reflect an insert on the following cycle; drain emits one entry per handshake.
// Backpressure: in_ready only in ACCUM without start; drain outputs hold while out_valid & ~out_ready.
module topk_sorted_buffer #(
  parameter int K      = 8,
  parameter int DIST_W = 32,
  parameter int IDX_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DIST_W-1:0]      in_distance,
  input  logic [IDX_W-1:0]       in_index,
  input  logic                   in_last,
  input  logic [DIST_W-1:0]      running_mean,
  output logic [DIST_W-1:0]      threshold,
  output logic [$clog2(K+1)-1:0] count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIST_W-1:0]      out_distance,
  output logic [IDX_W-1:0]       out_index,
  output logic [$clog2(K)-1:0]   out_rank,
  output logic                   out_last,
  output logic                   done,
`ifdef TOPK_STATS_EN
  output logic [31:0]            stat_accepted,
  output logic [31:0]            stat_rejected,
`endif
  output logic                   busy
);
  localparam int CW = $clog2(K+1);
  localparam int RW = $clog2(K);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [DIST_W-1:0] dist_q [K];
  logic [IDX_W-1:0]  idx_q  [K];
  logic [K-1:0]      vld_q;
  logic [CW-1:0]     count_q;
  logic [RW-1:0]     rd_q;
  logic              done_q;

  logic [DIST_W-1:0] dist_d [K];
  logic [IDX_W-1:0]  idx_d  [K];
  logic [K-1:0]      vld_d;
  logic              accept, ins_hit, out_hs, hs_last, full;
  logic [RW-1:0]     ins_pos;

  assign in_ready = (state_q == S_ACCUM) & ~start;
  assign accept   = in_valid & in_ready;
  assign full     = (count_q == CW'(K));

  // Descending scan so the lowest slot that beats the candidate wins; strict < keeps incumbents ahead on ties.
  always_comb begin
    ins_hit = 1'b0;
    ins_pos = '0;
    for (int i = K-1; i >= 0; i--) begin
      if (!vld_q[i] || (in_distance < dist_q[i])) begin
        ins_hit = 1'b1;
        ins_pos = RW'(i);
      end
    end
    dist_d = dist_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    for (int i = 1; i < K; i++) begin
      if (i > int'(ins_pos)) begin
        dist_d[i] = dist_q[i-1];
        idx_d[i]  = idx_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
    dist_d[ins_pos] = in_distance;
    idx_d[ins_pos]  = in_index;
    vld_d[ins_pos]  = 1'b1;
  end

  assign out_valid    = (state_q == S_DRAIN) && (count_q != '0);
  assign out_hs       = out_valid & out_ready;
  assign out_last     = out_valid && (CW'(rd_q) == count_q - CW'(1));
  assign hs_last      = out_hs & out_last;
  assign out_distance = out_valid ? dist_q[rd_q] : '0;
  assign out_index    = out_valid ? idx_q[rd_q] : '0;
  assign out_rank     = rd_q;
  assign count        = count_q;
  assign threshold    = full ? dist_q[K-1] : running_mean;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q | ((state_q == S_DRAIN) && (count_q == '0) && !start);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ACCUM;
      S_ACCUM: begin
        if (start)                  state_d = S_ACCUM;
        else if (accept && in_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (start)                  state_d = S_ACCUM;
        else if (count_q == '0)     state_d = S_IDLE;
        else if (hs_last)           state_d = S_IDLE;
      end
      default:                      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      vld_q   <= '0;
      count_q <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= '0;
        idx_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= hs_last & ~start;
      if (start) begin
        vld_q   <= '0;
        count_q <= '0;
        rd_q    <= '0;
      end else begin
        if (accept && ins_hit) begin
          dist_q <= dist_d;
          idx_q  <= idx_d;
          vld_q  <= vld_d;
          if (!full) count_q <= count_q + CW'(1);
        end
        if (out_hs) rd_q <= out_last ? '0 : rd_q + RW'(1);
      end
    end
  end

`ifdef TOPK_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || start) begin
      stat_accepted <= '0;
      stat_rejected <= '0;
    end else if (accept) begin
      if (ins_hit) begin
        if (stat_accepted != '1) stat_accepted <= stat_accepted + 32'd1;
      end else begin
        if (stat_rejected != '1) stat_rejected <= stat_rejected + 32'd1;
      end
    end
  end
`endif

endmodule
